// File: rtl/bcd_seg7_scanner.sv
// Two-digit multiplexed 7-segment driver for a packed BCD value, with a
// shadow/display double buffer. Optional leading-zero blanking via SEG_LZB_EN.
module bcd_seg7_scanner #(
  parameter int SCAN_DIV = 50000,
  parameter int DEAD_CYC = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] bcd,
  input  logic       load,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_start,
  output logic       bad
);

  localparam int CW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {BLANK, DIG0, DIG1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    shadow_q, shadow_d;
  logic [7:0]    disp_q, disp_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          fs_q, fs_d;
  logic          bad_q, bad_d;
  logic          tick;
  logic          boundary;
  logic          dead;

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'd0:    enc = 7'h40;
      4'd1:    enc = 7'h79;
      4'd2:    enc = 7'h24;
      4'd3:    enc = 7'h30;
      4'd4:    enc = 7'h19;
      4'd5:    enc = 7'h12;
      4'd6:    enc = 7'h02;
      4'd7:    enc = 7'h78;
      4'd8:    enc = 7'h00;
      4'd9:    enc = 7'h10;
      default: enc = 7'h06;
    endcase
  endfunction

  always_comb begin
    tick     = (cnt_q == CW'(SCAN_DIV - 1));
    dead     = (int'(cnt_q) < DEAD_CYC);
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    state_d  = state_q;
    boundary = 1'b0;
    shadow_d = load ? bcd : shadow_q;
    disp_d   = disp_q;
    fs_d     = 1'b0;
    bad_d    = bad_q;
    seg_d    = 7'h7F;
    an_d     = 2'b11;

    if (tick) begin
      case (state_q)
        BLANK:   begin state_d = DIG0; boundary = 1'b1; end
        DIG0:    state_d = DIG1;
        DIG1:    begin state_d = DIG0; boundary = 1'b1; end
        default: state_d = BLANK;
      endcase
    end

    // shadow_d already carries a coincident load, giving the bypass for free
    if (boundary) begin
      disp_d = shadow_d;
      fs_d   = 1'b1;
      bad_d  = (shadow_d[7:4] > 4'd9) || (shadow_d[3:0] > 4'd9);
    end

    case (state_q)
      DIG0: begin
        seg_d = enc(disp_q[3:0]);
        an_d  = 2'b10;
      end
      DIG1: begin
        seg_d = enc(disp_q[7:4]);
        an_d  = 2'b01;
`ifdef SEG_LZB_EN
        if (disp_q[7:4] == 4'd0) an_d = 2'b11;
`endif
      end
      default: ;
    endcase
    if (dead) an_d = 2'b11;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= BLANK;
      cnt_q    <= '0;
      shadow_q <= '0;
      disp_q   <= '0;
      seg_q    <= 7'h7F;
      an_q     <= 2'b11;
      fs_q     <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      fs_q     <= fs_d;
      bad_q    <= bad_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_start = fs_q;
  assign bad         = bad_q;

endmodule
